// File: rtl/imem_load_ctrl_if.sv
// Bus bundle between the instruction-memory load controller, the fetch
// stage, the program loader and the instruction memory.
// slave  : controller side (drives fetch result, loader handshake, memory port)
// master : environment side (pipeline, loader and memory model)
interface imem_load_ctrl_if;
  logic [21:0] pc;
  logic [21:0] instr;
  logic        fetch_stall;
  logic        cpu_rst;
  logic        load_req;
  logic        ld_valid;
  logic [21:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [6:0]  ld_count;
  logic        ld_ovf;
  logic [21:0] ld_checksum;
  logic [21:0] mem_a;
  logic [21:0] mem_wd;
  logic        mem_we;
  logic [21:0] mem_rd;

  modport slave (
    input  pc, load_req, ld_valid, ld_data, ld_last, mem_rd,
    output instr, fetch_stall, cpu_rst, ld_ready, ld_count, ld_ovf,
           ld_checksum, mem_a, mem_wd, mem_we
  );

  modport master (
    output pc, load_req, ld_valid, ld_data, ld_last, mem_rd,
    input  instr, fetch_stall, cpu_rst, ld_ready, ld_count, ld_ovf,
           ld_checksum, mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller.
// Shares a single-port instruction memory between the fetch stage (RUN) and
// a streaming program loader (LOAD). After a load, one DRAIN cycle pulses
// cpu_rst so the pipeline restarts at PC 0.
// Optional feature: define IMEM_LOAD_CHECKSUM_EN to accumulate an XOR
// checksum of every accepted loader word on ld_checksum (otherwise it is 0).
module imem_load_ctrl #(
  parameter int          DEPTH     = 101,
  parameter logic [21:0] NOP_INSTR = 22'b0
) (
  input  logic            clk,
  input  logic            reset,
  imem_load_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, LOAD, DRAIN} state_t;

  localparam logic [19:0] LAST_IDX  = 20'(DEPTH - 1);
  localparam logic [19:0] DEPTH_IDX = 20'(DEPTH);

  state_t      state_q;
  logic [19:0] wr_ptr_q;
  logic [6:0]  ld_count_q;
  logic        ld_ovf_q;

  logic        ld_ready;
  logic        accept;
  logic        at_last_idx;
  logic        unused_pc_lsb;

  // Byte-offset bits of the fetch address do not select a word.
  assign unused_pc_lsb = ^bus.pc[1:0];

  assign at_last_idx = (wr_ptr_q == LAST_IDX);
  assign accept      = bus.ld_valid && ld_ready;

  // Control FSM plus write pointer and load statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      wr_ptr_q   <= '0;
      ld_count_q <= '0;
      ld_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.load_req) begin
            state_q    <= LOAD;
            wr_ptr_q   <= '0;
            ld_count_q <= '0;
            ld_ovf_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            wr_ptr_q   <= wr_ptr_q + 20'd1;
            ld_count_q <= ld_count_q + 7'd1;
            if (bus.ld_last || at_last_idx) state_q <= DRAIN;
            // Memory full before the program ended: flag truncation.
            if (at_last_idx && !bus.ld_last) ld_ovf_q <= 1'b1;
          end
        end
        DRAIN:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [21:0] ld_checksum_q;
  logic [21:0] ld_checksum_d;

  assign ld_checksum_d = ld_checksum_q ^ bus.ld_data;

  // XOR accumulator, cleared on reset and on every new load.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_checksum_q <= '0;
    end else if (state_q == RUN && bus.load_req) begin
      ld_checksum_q <= '0;
    end else if (accept) begin
      ld_checksum_q <= ld_checksum_d;
    end
  end

  assign bus.ld_checksum = ld_checksum_q;
`else
  assign bus.ld_checksum = '0;
`endif

  // Memory port, fetch result and handshake decoded from the current state.
  // Write enable, ready and restart are held low while reset is asserted so
  // an aborted load cannot write or restart the core on its way out.
  always_comb begin
    bus.mem_a       = bus.pc;
    bus.mem_wd      = bus.ld_data;
    bus.mem_we      = 1'b0;
    bus.instr       = NOP_INSTR;
    bus.fetch_stall = 1'b0;
    bus.cpu_rst     = 1'b0;
    ld_ready        = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.pc[21:2] < DEPTH_IDX) bus.instr = bus.mem_rd;
      end
      LOAD: begin
        bus.fetch_stall = 1'b1;
        ld_ready        = !reset;
        bus.mem_a       = {wr_ptr_q, 2'b00};
        bus.mem_we      = bus.ld_valid && !reset;
      end
      DRAIN: begin
        bus.fetch_stall = 1'b1;
        bus.cpu_rst     = !reset;
      end
      default: ;
    endcase
  end

  assign bus.ld_ready = ld_ready;
  assign bus.ld_count = ld_count_q;
  assign bus.ld_ovf   = ld_ovf_q;

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 Parameter DEPTH, default 101, number of 22-bit instruction words in the instruction memory.
REQ-002 Parameter NOP_INSTR, default 22'b0, word returned to fetch while the memory is not owned by fetch.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc  input  22  fetch byte address from the pipeline; word index is pc[21:2].
REQ-006 instr  output  22  instruction delivered to the fetch stage.
REQ-007 fetch_stall  output  1  high while fetch shall hold the PC.
REQ-008 cpu_rst  output  1  one-cycle pulse requesting a pipeline restart at PC 0.
REQ-009 load_req  input  1  start-of-load request, sampled only in RUN.
REQ-010 ld_valid  input  1  loader word valid.
REQ-011 ld_data  input  22  loader instruction word.
REQ-012 ld_last  input  1  marks the final word of the program.
REQ-013 ld_ready  output  1  controller accepts ld_data this cycle.
REQ-014 ld_count  output  7  number of words written in the current or last load.
REQ-015 ld_ovf  output  1  sticky: the load was truncated at DEPTH words.
REQ-016 ld_checksum  output  22  XOR of all accepted words (see Configuration).
REQ-017 mem_a  output  22  memory byte address.
REQ-018 mem_wd  output  22  memory write data.
REQ-019 mem_we  output  1  memory write enable, written on the rising clk edge.
REQ-020 mem_rd  input  22  combinational memory read data.

Function
REQ-021 FSM states: RUN, LOAD, DRAIN.
REQ-022 RUN: mem_a=pc, mem_we=0, instr=mem_rd in the same cycle (zero latency), fetch_stall=0, ld_ready=0.
REQ-023 RUN to LOAD when load_req=1; on entry, clear write pointer, ld_count, ld_ovf and ld_checksum.
REQ-024 LOAD: fetch_stall=1, instr=NOP_INSTR, ld_ready=1, mem_a={wr_ptr,2'b00}, mem_wd=ld_data.
REQ-025 LOAD: mem_we=ld_valid&ld_ready; each accepted word increments wr_ptr and ld_count by 1.
REQ-026 LOAD to DRAIN when an accepted word has ld_last=1, or when the accepted word is at index DEPTH-1.
REQ-027 Word accepted at index DEPTH-1 with ld_last=0: the word is written, ld_ovf is set and the load ends; no later word is written.
REQ-028 DRAIN (exactly one cycle): fetch_stall=1, instr=NOP_INSTR, ld_ready=0, mem_we=0, cpu_rst=1; then RUN.
REQ-029 load_req is ignored in LOAD and DRAIN.
REQ-030 ld_valid is ignored in RUN and DRAIN.
REQ-031 RUN with pc[21:2] >= DEPTH: instr=NOP_INSTR, mem_rd is ignored.
REQ-032 ld_count, ld_ovf and ld_checksum hold their values after the load until the next LOAD entry.

Reset
REQ-033 reset=1 forces, on the next edge: state RUN, wr_ptr=0, ld_count=0, ld_ovf=0, ld_checksum=0.
REQ-034 Reset outputs: cpu_rst=0, ld_ready=0, mem_we=0, fetch_stall=0.
REQ-035 Reset in the middle of a load aborts it and returns to RUN; words already written stay in memory; no cpu_rst pulse is issued.

Configuration
REQ-036 Macro IMEM_LOAD_CHECKSUM_EN defined: ld_checksum accumulates XOR of every accepted ld_data.
REQ-037 Macro IMEM_LOAD_CHECKSUM_EN undefined: ld_checksum is constant 0 and no accumulator register exists.

Verification
REQ-038 Out of reset, pc=8, mem_rd=X -> instr=X in the same cycle, fetch_stall=0.
REQ-039 load_req, then 3 words 0x26808,0x26809,0x268B2 (last on 3rd) -> mem_we at addresses 0,4,8; ld_count=3; one cpu_rst cycle; RUN next cycle.
REQ-040 ld_valid toggling 1,0,1 in LOAD -> exactly 2 writes, to addresses 0 and 4; instr=NOP_INSTR throughout LOAD.
REQ-041 101 words with ld_last never set -> 101 writes, last at address 400; ld_ovf=1; DRAIN; word 102 not written.
REQ-042 reset after the 2nd of 5 words -> RUN the next cycle, ld_count=0, no cpu_rst, no further mem_we.
REQ-043 With IMEM_LOAD_CHECKSUM_EN defined, words 0x3 and 0x5 -> ld_checksum=0x6; with the macro undefined -> ld_checksum=0.
